data_store_buffer: RTL

//  Posted-write buffer between the single-cycle CPU data port and a slow data memory.

---
 rtl/data_store_buffer_pkg.sv | 12 +
 rtl/store_buffer_match.sv | 34 +++
 rtl/data_store_buffer.sv | 119 +++++++++++
 3 files changed

// File: rtl/data_store_buffer_pkg.sv
// Shared definitions for the data store buffer: word-address split and pointer sizing.
package data_store_buffer_pkg;

    // Byte-address bits below the word address; only word accesses are supported.
    localparam int WORD_LSB = 2;

    // Pointer width for a power-of-two entry count (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-first address match over the pending-store entries.
// Scans from tail-1 back toward the oldest entry; the first valid hit wins.
module store_buffer_match
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 30,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-1:0]    waddr [DEPTH],
    input  logic [PW-1:0]    tail,
    input  logic [AW-1:0]    key,
    output logic             hit,
    output logic [PW-1:0]    sel_idx
);

    logic [PW-1:0] idx;

    // Priority select: age 0 (most recent store) first, so forwarding returns the youngest data.
    always_comb begin
        hit     = 1'b0;
        sel_idx = '0;
        idx     = '0;
        for (int j = 1; j <= DEPTH; j++) begin
            idx = tail - PW'(j);
            if (!hit && valid[idx] && (waddr[idx] == key)) begin
                hit     = 1'b1;
                sel_idx = idx;
            end
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// Posted-write buffer between the CPU data port and a slow data memory.
// Stores are queued and drained in order through a valid/ready write port; loads
// forward from the youngest matching pending store, else read memory.
// Optional feature macro: STORE_COALESCE_EN (merge a store into the newest entry
// when it targets the same word and that entry is not the one being presented).
module data_store_buffer
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wd,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_ra,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [DATA_W-1:0] mem_wd
);

    localparam int PW  = ptr_width(DEPTH);
    localparam int WAW = ADDR_W - WORD_LSB;

    logic [WAW-1:0]    ent_waddr [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW:0]       count;
    logic [DEPTH-1:0]  valid;
    logic [WAW-1:0]    cpu_waddr;
    logic              full;
    logic              empty;
    logic              coalesce;
    logic              enq;
    logic              deq;
    logic              hit;
    logic [PW-1:0]     hit_idx;

    assign cpu_waddr = cpu_a[ADDR_W-1:WORD_LSB];
    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);

    // An entry is live when its distance from head is below the occupancy count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, PW'(i) - head} < count);
        end
    end

`ifdef STORE_COALESCE_EN
    logic [PW-1:0] tail_m1;
    assign tail_m1  = tail - PW'(1);
    // The newest entry may absorb the store unless it is the head currently on the write port.
    assign coalesce = cpu_we & ~empty & (ent_waddr[tail_m1] == cpu_waddr) & (tail_m1 != head);
`else
    assign coalesce = 1'b0;
`endif

    // Stall depends only on occupancy, never on mem_wready, so there is no memory-to-CPU comb path.
    assign cpu_stall  = cpu_we & full & ~coalesce & ~reset;
    assign enq        = cpu_we & ~cpu_stall & ~coalesce;
    assign mem_wvalid = ~empty;
    assign deq        = mem_wvalid & mem_wready;

    assign mem_wa = {ent_waddr[head], {WORD_LSB{1'b0}}};
    assign mem_wd = ent_data[head];
    assign mem_ra = cpu_a;

    store_buffer_match #(
        .DEPTH (DEPTH),
        .AW    (WAW),
        .PW    (PW)
    ) u_match (
        .valid   (valid),
        .waddr   (ent_waddr),
        .tail    (tail),
        .key     (cpu_waddr),
        .hit     (hit),
        .sel_idx (hit_idx)
    );

    // Load data: forwarded pending store wins over memory.
    assign cpu_rd = hit ? ent_data[hit_idx] : mem_rd;

    // Pointer and occupancy update; reset drops every pending store.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            count <= count + (PW+1)'(enq) - (PW+1)'(deq);
        end
    end

    // Entry storage; contents need no reset because validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_waddr[tail] <= cpu_waddr;
            ent_data[tail]  <= cpu_wd;
        end
`ifdef STORE_COALESCE_EN
        else if (coalesce) begin
            ent_data[tail_m1] <= cpu_wd;
        end
`endif
    end

endmodule
